seg7_scan_driver: RTL and testbench

Parametrised multiplexed seven-segment display driver: `DIGITS`-digit scanning, on-chip scan and blink dividers, and double-buffered display data. New values are applied only at frame boundaries, so the display never tears. An optional serial shift-out engine sends the committed frame to an external shift-register display. It sits between the game/score logic and the board's segment/anode pins, replacing the fixed 4-digit, externally clocked driver.

---
 rtl/seg7_scan_driver_if.sv | 27 ++
 rtl/seg7_scan_driver.sv | 170 +++++++++++++++++
 tb/tb_seg7_scan_driver.sv | 176 +++++++++++++++++
 3 files changed

// File: rtl/seg7_scan_driver_if.sv
// rtl/seg7_scan_driver_if.sv - host/display signal bundle for seg7_scan_driver
interface seg7_scan_driver_if #(
  parameter int DIGITS = 8
);
  logic                load;
  logic [4*DIGITS-1:0] data;
  logic [DIGITS-1:0]   point;
  logic [DIGITS-1:0]   blink_en;
  logic [DIGITS-1:0]   digit_en;
  logic [7:0]          segment;
  logic [DIGITS-1:0]   anode;
  logic                frame_start;
  logic                sclk;
  logic                sdat;
  logic                slatch;
  logic                ser_busy;

  modport master (
    output load, data, point, blink_en, digit_en,
    input  segment, anode, frame_start, sclk, sdat, slatch, ser_busy
  );

  modport slave (
    input  load, data, point, blink_en, digit_en,
    output segment, anode, frame_start, sclk, sdat, slatch, ser_busy
  );
endinterface

// File: rtl/seg7_scan_driver.sv
// rtl/seg7_scan_driver.sv - multiplexed seven-segment scan driver with frame-synchronous double buffering
// Optional serial shift-out engine built when SEG7_SERIAL_EN is defined.
module seg7_scan_driver #(
  parameter int DIGITS    = 8,
  parameter int SCAN_DIV  = 1024,
  parameter int BLINK_DIV = 1 << 22
) (
  input logic               clk,
  input logic               rst,
  seg7_scan_driver_if.slave bus
);
  localparam int PCW = $clog2(SCAN_DIV);
  localparam int IDW = $clog2(DIGITS);
  localparam int BCW = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
  localparam logic [PCW-1:0] PC_LAST = PCW'(SCAN_DIV - 1);
  localparam logic [IDW-1:0] ID_LAST = IDW'(DIGITS - 1);
  localparam logic [BCW-1:0] BC_LAST = BCW'(BLINK_DIV - 1);

  function automatic logic [6:0] hex7(input logic [3:0] n);
    case (n)
      4'h0: hex7 = 7'h3F;  4'h1: hex7 = 7'h06;  4'h2: hex7 = 7'h5B;  4'h3: hex7 = 7'h4F;
      4'h4: hex7 = 7'h66;  4'h5: hex7 = 7'h6D;  4'h6: hex7 = 7'h7D;  4'h7: hex7 = 7'h07;
      4'h8: hex7 = 7'h7F;  4'h9: hex7 = 7'h6F;  4'hA: hex7 = 7'h77;  4'hB: hex7 = 7'h7C;
      4'hC: hex7 = 7'h39;  4'hD: hex7 = 7'h5E;  4'hE: hex7 = 7'h79;  default: hex7 = 7'h71;
    endcase
  endfunction

  logic [PCW-1:0]      pc_q, pc_d;
  logic [IDW-1:0]      idx_q, idx_d;
  logic [BCW-1:0]      bcnt_q, bcnt_d;
  logic                phase_q, phase_d;
  logic [4*DIGITS-1:0] sh_data_q, sh_data_d, dp_data_q, dp_data_d;
  logic [DIGITS-1:0]   sh_point_q, sh_point_d, dp_point_q, dp_point_d;
  logic [DIGITS-1:0]   sh_blink_q, sh_blink_d, dp_blink_q, dp_blink_d;
  logic [DIGITS-1:0]   sh_den_q, sh_den_d, dp_den_q, dp_den_d;
  logic [7:0]          segment_q, segment_d;
  logic [DIGITS-1:0]   anode_q, anode_d;
  logic                frame_start_q, frame_start_d;
  logic                scan_wrap, boundary, dark;
  logic [3:0]          nib;

  always_comb begin
    scan_wrap = (pc_q == PC_LAST);
    boundary  = scan_wrap && (idx_q == ID_LAST);
    pc_d      = scan_wrap ? '0 : pc_q + 1'b1;
    idx_d     = idx_q;
    if (scan_wrap) idx_d = boundary ? '0 : idx_q + 1'b1;
    bcnt_d    = (bcnt_q == BC_LAST) ? '0 : bcnt_q + 1'b1;
    phase_d   = (bcnt_q == BC_LAST) ? ~phase_q : phase_q;
    // Shadow takes the load even on a boundary; display commits the pre-load shadow.
    sh_data_d  = bus.load ? bus.data     : sh_data_q;
    sh_point_d = bus.load ? bus.point    : sh_point_q;
    sh_blink_d = bus.load ? bus.blink_en : sh_blink_q;
    sh_den_d   = bus.load ? bus.digit_en : sh_den_q;
    dp_data_d  = boundary ? sh_data_q  : dp_data_q;
    dp_point_d = boundary ? sh_point_q : dp_point_q;
    dp_blink_d = boundary ? sh_blink_q : dp_blink_q;
    dp_den_d   = boundary ? sh_den_q   : dp_den_q;
    nib        = dp_data_q[{idx_q, 2'b00} +: 4];
    dark       = !dp_den_q[idx_q] || (dp_blink_q[idx_q] && phase_q);
    anode_d    = dark ? '1 : ~(DIGITS'(1) << idx_q);
    segment_d  = dark ? 8'hFF : ~{dp_point_q[idx_q], hex7(nib)};
    frame_start_d = boundary;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pc_q          <= '0;
      idx_q         <= '0;
      bcnt_q        <= '0;
      phase_q       <= 1'b0;
      sh_data_q     <= '0;
      sh_point_q    <= '0;
      sh_blink_q    <= '0;
      sh_den_q      <= '0;
      dp_data_q     <= '0;
      dp_point_q    <= '0;
      dp_blink_q    <= '0;
      dp_den_q      <= '0;
      segment_q     <= 8'hFF;
      anode_q       <= '1;
      frame_start_q <= 1'b0;
    end else begin
      pc_q          <= pc_d;
      idx_q         <= idx_d;
      bcnt_q        <= bcnt_d;
      phase_q       <= phase_d;
      sh_data_q     <= sh_data_d;
      sh_point_q    <= sh_point_d;
      sh_blink_q    <= sh_blink_d;
      sh_den_q      <= sh_den_d;
      dp_data_q     <= dp_data_d;
      dp_point_q    <= dp_point_d;
      dp_blink_q    <= dp_blink_d;
      dp_den_q      <= dp_den_d;
      segment_q     <= segment_d;
      anode_q       <= anode_d;
      frame_start_q <= frame_start_d;
    end
  end

  assign bus.segment     = segment_q;
  assign bus.anode       = anode_q;
  assign bus.frame_start = frame_start_q;

`ifdef SEG7_SERIAL_EN
  typedef enum logic [1:0] {S_IDLE, S_SHIFT, S_LATCH} ser_state_e;
  localparam int HCW = $clog2(16 * DIGITS);
  localparam logic [HCW-1:0] HC_LAST = HCW'(16 * DIGITS - 1);

  ser_state_e          state_q, state_d;
  logic [8*DIGITS-1:0] sr_q, sr_d, frame_pat;
  logic [HCW-1:0]      hc_q, hc_d;
  logic                dirty_q, dirty_d;

  // Highest digit sits in the top byte so it leaves first, bit 7 leading.
  always_comb begin
    frame_pat = '0;
    for (int i = 0; i < DIGITS; i++)
      frame_pat[8*i +: 8] = {sh_point_q[i], hex7(sh_data_q[4*i +: 4])};
  end

  always_comb begin
    state_d = state_q;
    sr_d    = sr_q;
    hc_d    = hc_q;
    dirty_d = bus.load ? 1'b1 : (boundary ? 1'b0 : dirty_q);
    case (state_q)
      S_IDLE: begin
        if (boundary && dirty_q) begin
          state_d = S_SHIFT;
          sr_d    = frame_pat;
          hc_d    = '0;
        end
      end
      S_SHIFT: begin
        hc_d = hc_q + 1'b1;
        if (hc_q[0]) sr_d = {sr_q[8*DIGITS-2:0], 1'b0};
        if (hc_q == HC_LAST) state_d = S_LATCH;
      end
      S_LATCH: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      sr_q    <= '0;
      hc_q    <= '0;
      dirty_q <= 1'b0;
    end else begin
      state_q <= state_d;
      sr_q    <= sr_d;
      hc_q    <= hc_d;
      dirty_q <= dirty_d;
    end
  end

  assign bus.sclk     = (state_q == S_SHIFT) && hc_q[0];
  assign bus.sdat     = (state_q == S_SHIFT) && sr_q[8*DIGITS-1];
  assign bus.slatch   = (state_q == S_LATCH);
  assign bus.ser_busy = (state_q != S_IDLE);
`else
  assign bus.sclk     = 1'b0;
  assign bus.sdat     = 1'b0;
  assign bus.slatch   = 1'b0;
  assign bus.ser_busy = 1'b0;
`endif
endmodule

// File: tb/tb_seg7_scan_driver.sv
// tb/tb_seg7_scan_driver.sv - scoreboard bench for seg7_scan_driver (8-digit scan, 2-digit serial)
module tb_seg7_scan_driver;
  localparam int ND = 8, SD = 4, BD = 8, FR = ND * SD;

  logic clk = 1'b0, rst = 1'b1, rst2 = 1'b1;
  always #5 clk = ~clk;

  seg7_scan_driver_if #(.DIGITS(ND)) bus ();
  seg7_scan_driver_if #(.DIGITS(2))  bus2 ();

  seg7_scan_driver #(.DIGITS(ND), .SCAN_DIV(SD), .BLINK_DIV(BD)) dut (.clk(clk), .rst(rst), .bus(bus));
  seg7_scan_driver #(.DIGITS(2), .SCAN_DIV(4), .BLINK_DIV(8)) dut2 (.clk(clk), .rst(rst2), .bus(bus2));

  int n_checks = 0, n_fail = 0;
  int cyc = 0, cyc2 = 0, frame_no = 0;
  bit mon_en = 1'b0;

  always @(posedge clk) cyc  <= rst  ? 0 : cyc + 1;
  always @(posedge clk) cyc2 <= rst2 ? 0 : cyc2 + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  logic [6:0] hex_tab [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                               7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};

  typedef struct { int frame; int slot; logic [7:0] an; logic [7:0] seg; } exp_t;
  exp_t sb[$];

  // Expected slot contents for frame f; blink phase taken from cycles since reset.
  task automatic push_frame(input int f, input logic [31:0] d, input logic [7:0] p,
                            input logic [7:0] bl, input logic [7:0] en);
    for (int k = 0; k < ND; k++) begin
      exp_t e;
      logic ph;
      logic [3:0] nb;
      ph = (((f * FR + k * SD + 1) / BD) % 2) == 1;
      nb = d[4*k +: 4];
      e.frame = f;
      e.slot  = k;
      if (!en[k] || (bl[k] && ph)) begin
        e.an  = 8'hFF;
        e.seg = 8'hFF;
      end else begin
        e.an  = ~(8'h01 << k);
        e.seg = ~{p[k], hex_tab[nb]};
      end
      sb.push_back(e);
    end
  endtask

  task automatic do_load(input int at_edge, input logic [31:0] d, input logic [7:0] p,
                         input logic [7:0] bl, input logic [7:0] en);
    while (cyc < at_edge - 1) @(negedge clk);
    bus.load = 1'b1; bus.data = d; bus.point = p; bus.blink_en = bl; bus.digit_en = en;
    @(negedge clk);
    bus.load = 1'b0;
  endtask

  // Monitor: one expectation per digit slot, sampled mid-slot after each frame_start.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (mon_en && bus.frame_start) begin
        frame_no++;
        check($sformatf("frame_start_cycle f%0d", frame_no), cyc, frame_no * FR);
        for (int k = 0; k < ND; k++) begin
          repeat ((k == 0) ? 2 : SD) @(negedge clk);
          if (sb.size() > 0 && sb[0].frame == frame_no && sb[0].slot == k) begin
            e = sb.pop_front();
            check($sformatf("anode f%0d d%0d", frame_no, k), bus.anode, e.an);
            check($sformatf("segment f%0d d%0d", frame_no, k), bus.segment, e.seg);
          end
        end
      end
    end
  end

  initial begin
    #100000;
    n_fail++;
    $display("FAIL timeout: got no finish, expected finish before 100000");
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    logic [15:0] bits;
    logic [3:0]  exp_s;
    int b;
    bus.load = 0;  bus.data = '0;  bus.point = '0;  bus.blink_en = '0;  bus.digit_en = '0;
    bus2.load = 0; bus2.data = '0; bus2.point = '0; bus2.blink_en = '0; bus2.digit_en = '0;
    repeat (3) @(negedge clk);
    check("reset anode", bus.anode, 8'hFF);
    check("reset segment", bus.segment, 8'hFF);
    check("reset frame_start", bus.frame_start, 0);
    check("reset serial", {bus2.sclk, bus2.sdat, bus2.slatch, bus2.ser_busy}, 0);
    rst = 1'b0;
    mon_en = 1'b1;

    do_load(5, 32'h0123_4567, 8'h01, 8'h00, 8'hFF);
    push_frame(1, 32'h0123_4567, 8'h01, 8'h00, 8'hFF);
    do_load(40, 32'h89AB_CDEF, 8'h80, 8'h00, 8'hFF);
    push_frame(2, 32'h89AB_CDEF, 8'h80, 8'h00, 8'hFF);
    do_load(64, 32'h0000_00A5, 8'h00, 8'h00, 8'hFF);
    push_frame(3, 32'h0000_00A5, 8'h00, 8'h00, 8'hFF);
    do_load(100, 32'h0123_4567, 8'h01, 8'h04, 8'hFE);
    push_frame(4, 32'h0123_4567, 8'h01, 8'h04, 8'hFE);
    push_frame(5, 32'h0123_4567, 8'h01, 8'h04, 8'hFE);
    while (cyc < 190) @(negedge clk);
    check("scoreboard drained", sb.size(), 0);
    check("frames seen", frame_no, 5);

    while (cyc < 203) @(negedge clk);
    mon_en = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    check("midframe reset anode", bus.anode, 8'hFF);
    check("midframe reset segment", bus.segment, 8'hFF);
    check("midframe reset frame_start", bus.frame_start, 0);
    rst = 1'b0;
    while (!bus.frame_start && cyc < 40) @(negedge clk);
    check("restart frame_start cycle", cyc, 32);
    @(negedge clk); @(negedge clk);
    check("restart blank anode", bus.anode, 8'hFF);

    @(negedge clk);
    rst2 = 1'b0;
`ifdef SEG7_SERIAL_EN
    while (cyc2 < 2) @(negedge clk);
    bus2.load = 1'b1; bus2.data = 8'h10; bus2.digit_en = 2'b11;
    @(negedge clk);
    bus2.load = 1'b0;
    bits = 16'b0000_0110_0011_1111;
    while (cyc2 < 7) @(negedge clk);
    for (int c = 7; c <= 41; c++) begin
      if (c < 8 || c > 40) exp_s = 4'b0000;
      else if (c == 40) exp_s = 4'b1100;
      else begin
        b = (c - 8) / 2;
        exp_s = {1'b1, 1'b0, ((c - 8) % 2) == 1, bits[15 - b]};
      end
      check($sformatf("serial busy/latch/sclk/sdat c%0d", c),
            {bus2.ser_busy, bus2.slatch, bus2.sclk, bus2.sdat}, exp_s);
      @(negedge clk);
    end
    while (cyc2 < 42) @(negedge clk);
    bus2.load = 1'b1;
    @(negedge clk);
    bus2.load = 1'b0;
    while (cyc2 < 55) @(negedge clk);
    check("serial busy before abort", bus2.ser_busy, 1);
    rst2 = 1'b1;
    @(negedge clk);
    check("serial abort", {bus2.ser_busy, bus2.slatch, bus2.sclk, bus2.sdat}, 0);
`else
    while (cyc2 < 2) @(negedge clk);
    bus2.load = 1'b1; bus2.data = 8'h10; bus2.digit_en = 2'b11;
    @(negedge clk);
    bus2.load = 1'b0;
    for (int c = 0; c < 6; c++) begin
      while (cyc2 < 8 + 2 * c) @(negedge clk);
      check($sformatf("serial tied off c%0d", cyc2),
            {bus2.ser_busy, bus2.slatch, bus2.sclk, bus2.sdat}, 0);
    end
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
